shell_scheduler: RTL and testbench



---
 rtl/shell_scheduler.sv | 166 ++++++++++++++++
 tb/tb_shell_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/shell_scheduler.sv
// shell_scheduler
// Owns the shared pool of tank shells and arbitrates fire requests from two
// tanks. On every frame_clk edge each live shell is either killed, advanced by
// SHELL_STEP along its stored direction, or retired when it leaves the play
// field. At most one new shell is granted per frame, with a per-tank reload
// cooldown and round-robin tie breaking.
//
// Ports
//   frame_clk              frame clock, all state updates on posedge
//   Reset                  asynchronous, active-high reset
//   fire_i[1:0]            level fire request, bit p = tank p
//   tank{0,1}_{x,y}_i      tank positions, sampled on a grant
//   tank{0,1}_dir_i        facing: 0 up, 1 left, 2 down, 3 right
//   kill_i[N-1:0]          collision clear, bit i clears slot i
//   shell_valid_o[N-1:0]   slot i holds a live shell
//   shell_x_o, shell_y_o   slot i position at bits [10i+9:10i]
//   shell_owner_o[N-1:0]   tank that fired slot i
//   grant_o[1:0]           one-frame pulse, bit p = tank p granted this frame
module shell_scheduler #(
  parameter int          NUM_SHELLS = 4,
  parameter logic [9:0]  SHELL_STEP = 10'd4,
  parameter logic [7:0]  COOLDOWN   = 8'd30,
  parameter logic [9:0]  X_MIN      = 10'd1,
  parameter logic [9:0]  X_MAX      = 10'd639,
  parameter logic [9:0]  Y_MIN      = 10'd1,
  parameter logic [9:0]  Y_MAX      = 10'd479
) (
  input  logic                     frame_clk,
  input  logic                     Reset,
  input  logic [1:0]               fire_i,
  input  logic [9:0]               tank0_x_i,
  input  logic [9:0]               tank0_y_i,
  input  logic [9:0]               tank1_x_i,
  input  logic [9:0]               tank1_y_i,
  input  logic [1:0]               tank0_dir_i,
  input  logic [1:0]               tank1_dir_i,
  input  logic [NUM_SHELLS-1:0]    kill_i,
  output logic [NUM_SHELLS-1:0]    shell_valid_o,
  output logic [10*NUM_SHELLS-1:0] shell_x_o,
  output logic [10*NUM_SHELLS-1:0] shell_y_o,
  output logic [NUM_SHELLS-1:0]    shell_owner_o,
  output logic [1:0]               grant_o
);

  localparam int IW = (NUM_SHELLS > 1) ? $clog2(NUM_SHELLS) : 1;

  // Signed 11-bit copies so up/left moves near 0 go negative instead of wrapping.
  localparam logic signed [10:0] STEP_S = signed'({1'b0, SHELL_STEP});
  localparam logic signed [10:0] XMIN_S = signed'({1'b0, X_MIN});
  localparam logic signed [10:0] XMAX_S = signed'({1'b0, X_MAX});
  localparam logic signed [10:0] YMIN_S = signed'({1'b0, Y_MIN});
  localparam logic signed [10:0] YMAX_S = signed'({1'b0, Y_MAX});

  logic [NUM_SHELLS-1:0]    valid_q, valid_d;
  logic [NUM_SHELLS-1:0]    owner_q, owner_d;
  logic [10*NUM_SHELLS-1:0] x_q, x_d, y_q, y_d;
  logic [2*NUM_SHELLS-1:0]  dir_q, dir_d;
  logic [7:0]               cd0_q, cd0_d, cd1_q, cd1_d;
  logic                     last_q, last_d;
  logic [1:0]               grant_q, grant_d;

  logic [10*NUM_SHELLS-1:0] nx_pos, ny_pos;
  logic [NUM_SHELLS-1:0]    in_range;
  logic                     any_free;
  logic [IW-1:0]            free_idx;
  logic                     elig0, elig1, gnt0, gnt1;

  for (genvar i = 0; i < NUM_SHELLS; i++) begin : g_move
    logic signed [10:0] cx, cy, nx, ny;
    logic [1:0]         dir;
    assign dir = dir_q[2*i +: 2];
    assign cx  = signed'({1'b0, x_q[10*i +: 10]});
    assign cy  = signed'({1'b0, y_q[10*i +: 10]});
    assign nx  = (dir == 2'd3) ? cx + STEP_S : (dir == 2'd1) ? cx - STEP_S : cx;
    assign ny  = (dir == 2'd2) ? cy + STEP_S : (dir == 2'd0) ? cy - STEP_S : cy;
    assign in_range[i] = (nx >= XMIN_S) && (nx <= XMAX_S) &&
                         (ny >= YMIN_S) && (ny <= YMAX_S);
    assign nx_pos[10*i +: 10] = nx[9:0];
    assign ny_pos[10*i +: 10] = ny[9:0];
  end

  // Lowest-index free slot, judged on pre-edge occupancy only.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_SHELLS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        any_free = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  assign elig0 = fire_i[0] && (cd0_q == 8'd0);
  assign elig1 = fire_i[1] && (cd1_q == 8'd0);
  // On a tie the tank that did not win last time goes first.
  assign gnt0  = any_free && elig0 && (!elig1 || last_q);
  assign gnt1  = any_free && elig1 && (!elig0 || !last_q);

  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    for (int i = 0; i < NUM_SHELLS; i++) begin
      if (kill_i[i]) begin
        valid_d[i] = 1'b0;
      end else if (valid_q[i]) begin
        if (in_range[i]) begin
          x_d[10*i +: 10] = nx_pos[10*i +: 10];
          y_d[10*i +: 10] = ny_pos[10*i +: 10];
        end else begin
          valid_d[i] = 1'b0;
        end
      end
    end
    // The allocated slot was free before the edge, so it never collides with
    // a move of a live shell; the new shell first advances next frame.
    if (gnt0 || gnt1) begin
      valid_d[free_idx]         = 1'b1;
      owner_d[free_idx]         = gnt1;
      x_d[10*free_idx +: 10]    = gnt1 ? tank1_x_i   : tank0_x_i;
      y_d[10*free_idx +: 10]    = gnt1 ? tank1_y_i   : tank0_y_i;
      dir_d[2*free_idx +: 2]    = gnt1 ? tank1_dir_i : tank0_dir_i;
    end
  end

  always_comb begin
    cd0_d   = gnt0 ? COOLDOWN : ((cd0_q != 8'd0) ? cd0_q - 8'd1 : 8'd0);
    cd1_d   = gnt1 ? COOLDOWN : ((cd1_q != 8'd0) ? cd1_q - 8'd1 : 8'd0);
    last_d  = gnt0 ? 1'b0 : (gnt1 ? 1'b1 : last_q);
    grant_d = {gnt1, gnt0};
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      valid_q <= '0;
      owner_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      dir_q   <= '0;
      cd0_q   <= 8'd0;
      cd1_q   <= 8'd0;
      last_q  <= 1'b1;
      grant_q <= 2'b00;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      cd0_q   <= cd0_d;
      cd1_q   <= cd1_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  assign shell_valid_o = valid_q;
  assign shell_owner_o = owner_q;
  assign shell_x_o     = x_q;
  assign shell_y_o     = y_q;
  assign grant_o       = grant_q;

endmodule

// File: tb/tb_shell_scheduler.sv
// Scoreboard bench for shell_scheduler. A driver applies one frame of inputs
// per cycle, steps a behavioural model of the shell pool and pushes the
// expected post-edge outputs; a monitor pops one entry after every edge and
// compares it with the DUT.
module tb_shell_scheduler;
  localparam int N    = 4;
  localparam int STEP = 4;
  localparam int CD   = 30;

  logic           frame_clk = 1'b0;
  logic           Reset     = 1'b1;
  logic [1:0]     fire_i    = '0;
  logic [9:0]     tank0_x_i = '0, tank0_y_i = '0, tank1_x_i = '0, tank1_y_i = '0;
  logic [1:0]     tank0_dir_i = '0, tank1_dir_i = '0;
  logic [N-1:0]   kill_i = '0;
  logic [N-1:0]   shell_valid_o, shell_owner_o;
  logic [10*N-1:0] shell_x_o, shell_y_o;
  logic [1:0]     grant_o;

  shell_scheduler dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .fire_i        (fire_i),
    .tank0_x_i     (tank0_x_i),
    .tank0_y_i     (tank0_y_i),
    .tank1_x_i     (tank1_x_i),
    .tank1_y_i     (tank1_y_i),
    .tank0_dir_i   (tank0_dir_i),
    .tank1_dir_i   (tank1_dir_i),
    .kill_i        (kill_i),
    .shell_valid_o (shell_valid_o),
    .shell_x_o     (shell_x_o),
    .shell_y_o     (shell_y_o),
    .shell_owner_o (shell_owner_o),
    .grant_o       (grant_o)
  );

  always #5 frame_clk = ~frame_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integers per slot and per tank.
  int mv[N], mx[N], my[N], md[N], mo[N];
  int cd[2];
  int last_g;

  typedef struct {
    logic [N-1:0]    v;
    logic [10*N-1:0] x;
    logic [10*N-1:0] y;
    logic [N-1:0]    o;
    logic [1:0]      g;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; mx[i] = 0; my[i] = 0; md[i] = 0; mo[i] = 0;
    end
    cd[0] = 0; cd[1] = 0;
    last_g = 1;
  endtask

  task automatic model_step();
    int   free, w, nx, ny;
    int   px[2], py[2], pd[2];
    bit   e0, e1;
    exp_t e;
    px[0] = int'(tank0_x_i); py[0] = int'(tank0_y_i); pd[0] = int'(tank0_dir_i);
    px[1] = int'(tank1_x_i); py[1] = int'(tank1_y_i); pd[1] = int'(tank1_dir_i);
    free = -1;
    for (int i = 0; i < N; i++) if (mv[i] == 0 && free < 0) free = i;
    e0 = fire_i[0] && cd[0] == 0;
    e1 = fire_i[1] && cd[1] == 0;
    w = -1;
    if (free >= 0) begin
      if (e0 && e1) w = 1 - last_g;
      else if (e0) w = 0;
      else if (e1) w = 1;
    end
    for (int i = 0; i < N; i++) begin
      if (kill_i[i]) mv[i] = 0;
      else if (mv[i] != 0) begin
        nx = mx[i]; ny = my[i];
        case (md[i])
          0: ny = ny - STEP;
          1: nx = nx - STEP;
          2: ny = ny + STEP;
          default: nx = nx + STEP;
        endcase
        if (nx < 1 || nx > 639 || ny < 1 || ny > 479) mv[i] = 0;
        else begin mx[i] = nx; my[i] = ny; end
      end
    end
    if (w >= 0) begin
      mv[free] = 1; mx[free] = px[w]; my[free] = py[w]; md[free] = pd[w]; mo[free] = w;
      last_g = w;
    end
    for (int p = 0; p < 2; p++) begin
      if (p == w) cd[p] = CD;
      else if (cd[p] > 0) cd[p] = cd[p] - 1;
    end
    for (int i = 0; i < N; i++) begin
      e.v[i] = (mv[i] != 0);
      e.o[i] = (mo[i] != 0);
      e.x[10*i +: 10] = 10'(mx[i]);
      e.y[10*i +: 10] = 10'(my[i]);
    end
    e.g = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
    q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] f, input logic [9:0] ax, input logic [9:0] ay,
                       input logic [1:0] ad, input logic [9:0] bx, input logic [9:0] by,
                       input logic [1:0] bd, input logic [N-1:0] k);
    @(negedge frame_clk);
    #1;
    fire_i = f; kill_i = k;
    tank0_x_i = ax; tank0_y_i = ay; tank0_dir_i = ad;
    tank1_x_i = bx; tank1_y_i = by; tank1_dir_i = bd;
    model_step();
  endtask

  task automatic do_reset();
    @(negedge frame_clk);
    #1;
    Reset = 1'b1;
    fire_i = '0; kill_i = '0;
    model_reset();
    #1;
    check("rst_valid", shell_valid_o, '0);
    check("rst_grant", grant_o, '0);
    check("rst_owner", shell_owner_o, '0);
    check("rst_x", shell_x_o, '0);
    check("rst_y", shell_y_o, '0);
    repeat (2) @(negedge frame_clk);
    #1;
    Reset = 1'b0;
    model_step();
  endtask

  function automatic logic [9:0] rpos(input int hi);
    case ($urandom_range(0, 3))
      0:       rpos = 10'($urandom_range(1, 6));
      1:       rpos = 10'($urandom_range(hi - 5, hi));
      default: rpos = 10'($urandom_range(1, hi));
    endcase
  endfunction

  always @(posedge frame_clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("valid", shell_valid_o, mon_e.v);
      check("grant", grant_o, mon_e.g);
      for (int i = 0; i < N; i++) begin
        if (mon_e.v[i]) begin
          check($sformatf("x[%0d]", i), shell_x_o[10*i +: 10], mon_e.x[10*i +: 10]);
          check($sformatf("y[%0d]", i), shell_y_o[10*i +: 10], mon_e.y[10*i +: 10]);
          check($sformatf("owner[%0d]", i), shell_owner_o[i], mon_e.o[i]);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] k;
    model_reset();
    do_reset();

    // Held single fire: moving up, autofire every COOLDOWN+1 frames.
    repeat (70) drive(2'b01, 10'd320, 10'd240, 2'd0, 10'd0, 10'd0, 2'd0, '0);

    // Simultaneous fire from reset: alternate grants, pool fills, then kills.
    do_reset();
    repeat (90) drive(2'b11, 10'd100, 10'd200, 2'd3, 10'd500, 10'd300, 2'd1, '0);
    drive(2'b11, 10'd100, 10'd200, 2'd3, 10'd500, 10'd300, 2'd1, 4'b0010);
    repeat (5) drive(2'b11, 10'd100, 10'd200, 2'd3, 10'd500, 10'd300, 2'd1, '0);

    // Edge retirement right and top.
    do_reset();
    drive(2'b01, 10'd637, 10'd100, 2'd3, 10'd200, 10'd3, 2'd0, '0);
    drive(2'b10, 10'd637, 10'd100, 2'd3, 10'd200, 10'd3, 2'd0, '0);
    repeat (3) drive(2'b00, 10'd0, 10'd0, 2'd0, 10'd0, 10'd0, 2'd0, '0);
    drive(2'b00, 10'd0, 10'd0, 2'd0, 10'd0, 10'd0, 2'd0, '0);

    // Kill on the same edge as a grant: new shell must avoid the killed slot.
    do_reset();
    drive(2'b01, 10'd320, 10'd240, 2'd0, 10'd50, 10'd50, 2'd2, '0);
    drive(2'b10, 10'd320, 10'd240, 2'd0, 10'd50, 10'd50, 2'd2, 4'b0001);
    repeat (3) drive(2'b00, 10'd320, 10'd240, 2'd0, 10'd50, 10'd50, 2'd2, '0);

    // Randomized frames.
    for (int n = 0; n < 2500; n++) begin
      k = '0;
      for (int i = 0; i < N; i++) k[i] = ($urandom_range(0, 15) == 0);
      drive(($urandom_range(0, 4) == 0) ? 2'b00 : 2'($urandom_range(1, 3)),
            rpos(639), rpos(479), 2'($urandom_range(0, 3)),
            rpos(639), rpos(479), 2'($urandom_range(0, 3)), k);
    end

    // Reset mid-flight, then a tie from reset goes to tank 0.
    repeat (10) drive(2'b11, 10'd320, 10'd240, 2'd2, 10'd300, 10'd200, 2'd3, '0);
    do_reset();
    repeat (6) drive(2'b11, 10'd10, 10'd400, 2'd0, 10'd600, 10'd20, 2'd2, '0);

    @(posedge frame_clk);
    #3;
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
